// File: rtl/cp0_unit.sv
// cp0_unit: MIPS-style coprocessor 0 subset providing SR, Cause, EPC and PRId,
// exception and interrupt request generation, and ERET support.
//
// Ports:
//   clk       - clock; all state updates on its rising edge
//   rst       - synchronous active-high reset
//   en        - MTC0 write enable
//   addr      - CP0 register number for MFC0 read and MTC0 write
//   din       - MTC0 write data
//   pc        - PC of the victim instruction
//   bd        - victim instruction sits in a branch delay slot
//   exc_code  - pending synchronous exception code (0 = none)
//   hw_int    - level-sensitive hardware interrupt lines
//   eret      - ERET executing this cycle
//   req       - exception/interrupt request to fetch (redirect and flush)
//   epc_out   - current EPC value for the ERET redirect
//   dout      - MFC0 read data
module cp0_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] dout
);

  localparam logic [4:0]  ADDR_SR   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC  = 5'd14;
  localparam logic [4:0]  ADDR_PRID = 5'd15;
  localparam logic [31:0] PRID_VAL  = 32'h2024_0001;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  // EPC is word aligned; only bits [31:2] are stored
  logic [29:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_victim;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_wr_sr;
  logic        w_wr_epc;

  assign w_int_req = r_ie & ~r_exl & (|(hw_int & r_im));
  assign w_exc_req = ~r_exl & (exc_code != 5'd0);
  assign w_req     = w_int_req | w_exc_req;
  assign req       = w_req;

  // A delay-slot victim restarts at the branch, one word earlier (wraps).
  assign w_victim  = bd ? (pc - 32'd4) : pc;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
  assign w_epc   = {r_epc, 2'b00};
  assign epc_out = w_epc;

  assign w_wr_sr  = en && (addr == ADDR_SR);
  assign w_wr_epc = en && (addr == ADDR_EPC);

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_SR:    dout = w_sr;
      ADDR_CAUSE: dout = w_cause;
      ADDR_EPC:   dout = w_epc;
      ADDR_PRID:  dout = PRID_VAL;
      default:    dout = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= hw_int;
      if (w_req) begin
        // Taking the trap wins over any concurrent ERET or MTC0.
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : exc_code;
        r_bd      <= bd;
        r_epc     <= w_victim[31:2];
      end else begin
        if (w_wr_sr) begin
          r_im <= din[15:10];
          r_ie <= din[0];
          // ERET overrides only the EXL bit of a same-cycle SR write.
          r_exl <= eret ? 1'b0 : din[1];
        end else if (eret) begin
          r_exl <= 1'b0;
        end
        if (w_wr_epc) begin
          r_epc <= din[31:2];
        end
      end
    end
  end

endmodule
